// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11 single-wire controller.
// Holds the FSM state encoding, default tick counts and the frame checksum.
package dht_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_START_REL,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } dht_state_t;

  localparam int DEF_START_TICKS   = 1800;
  localparam int DEF_REL_TICKS     = 3;
  localparam int DEF_BIT1_THRESH   = 5;
  localparam int DEF_TIMEOUT_TICKS = 20;
  localparam int FRAME_W           = 40;
  localparam int TCNT_W            = 11;
  localparam int BITCNT_W          = 6;

  // Frame is B4..B0 with B4 in the top byte; B0 is the modulo-256 sum of the others.
  function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/dht_edge_sync.sv
// Two-flop synchronizer for the sensor pin plus rise/fall pulses
// against the previous synchronized sample.
module dht_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic sync_a;
  logic sync_b;
  logic prev;

  // Idle bus is pulled high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      prev   <= 1'b1;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
      prev   <= sync_b;
    end
  end

  assign rise = sync_b & ~prev;
  assign fall = ~sync_b & prev;

endmodule

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire read controller: host start pulse, response tracking,
// 40-bit deserialisation by high-phase width and checksum verification.
module dht11_ctrl
  import dht_pkg::*;
#(
  parameter int START_TICKS   = DEF_START_TICKS,
  parameter int REL_TICKS     = DEF_REL_TICKS,
  parameter int BIT1_THRESH   = DEF_BIT1_THRESH,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic       valid,
  output logic       chk_err,
  output logic       timeout,
  output logic       busy
);

  localparam logic [TCNT_W-1:0]   START_LAST = TCNT_W'(START_TICKS - 1);
  localparam logic [TCNT_W-1:0]   REL_LAST   = TCNT_W'(REL_TICKS - 1);
  localparam logic [TCNT_W-1:0]   THRESH_CNT = TCNT_W'(BIT1_THRESH);
  localparam logic [TCNT_W-1:0]   TMO_CNT    = TCNT_W'(TIMEOUT_TICKS);
  localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(FRAME_W - 1);

  dht_state_t          state;
  dht_state_t          state_nx;
  logic [TCNT_W-1:0]   tcnt;
  logic [BITCNT_W-1:0] bitcnt;
  logic [FRAME_W-1:0]  shreg;
  logic                rise;
  logic                fall;
  logic                oe;
  logic                shift_en;
  logic                tmo;
  logic                sensor_phase;

  dht_edge_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (dht_io),
    .rise (rise),
    .fall (fall)
  );

  // Open-drain: only ever pull low; the external pull-up supplies the high level.
  assign oe     = (state == S_START_LOW);
  assign dht_io = oe ? 1'b0 : 1'bz;
  assign busy   = (state != S_IDLE);

  assign sensor_phase = (state == S_WAIT_RESP) || (state == S_RESP_LOW) ||
                        (state == S_RESP_HIGH) || (state == S_BIT_LOW)  ||
                        (state == S_BIT_HIGH);

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    tmo      = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nx = S_START_LOW;
      S_START_LOW: if (tick && tcnt == START_LAST) state_nx = S_START_REL;
      S_START_REL: if (tick && tcnt == REL_LAST) state_nx = S_WAIT_RESP;
      S_WAIT_RESP: if (fall) state_nx = S_RESP_LOW;
      S_RESP_LOW:  if (rise) state_nx = S_RESP_HIGH;
      S_RESP_HIGH: if (fall) state_nx = S_BIT_LOW;
      S_BIT_LOW:   if (rise) state_nx = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (fall) begin
          shift_en = 1'b1;
          state_nx = (bitcnt == LAST_BIT) ? S_CHECK : S_BIT_LOW;
        end
      end
      S_CHECK:     state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
    // An edge in the same cycle as the limit already moved the state, so it wins.
    if (sensor_phase && state_nx == state && tcnt == TMO_CNT) begin
      tmo      = 1'b1;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      hum_int <= '0;
      hum_dec <= '0;
      tmp_int <= '0;
      tmp_dec <= '0;
      valid   <= 1'b0;
      chk_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      valid   <= 1'b0;
      chk_err <= 1'b0;
      timeout <= tmo;

      if (state_nx != state) tcnt <= '0;
      else if (tick)         tcnt <= tcnt + 1'b1;

      if (state == S_IDLE && state_nx == S_START_LOW) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (shift_en) begin
        shreg  <= {shreg[FRAME_W-2:0], (tcnt >= THRESH_CNT)};
        bitcnt <= bitcnt + 1'b1;
      end

      if (state == S_CHECK) begin
        if (checksum_ok(shreg)) begin
          hum_int <= shreg[39:32];
          hum_dec <= shreg[31:24];
          tmp_int <= shreg[23:16];
          tmp_dec <= shreg[15:8];
          valid   <= 1'b1;
        end else begin
          chk_err <= 1'b1;
        end
      end
    end
  end

endmodule
